// File: rtl/half_mult_operand_queue.sv
// Operand staging FIFO ahead of the binary16 multiplier: classifies each pair on push
// and presents a registered head. Optional saturating exception counter: HALF_MULT_EXC_CNT_EN.
module half_mult_operand_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_a,
    input  logic [15:0]              in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_float1,
    output logic [15:0]              out_float2,
    output logic [2:0]               out_class,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               exc_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        CLS_NORMAL = 3'd0,
        CLS_ZERO   = 3'd1,
        CLS_QNAN   = 3'd2,
        CLS_SNAN   = 3'd3,
        CLS_INF    = 3'd4
    } cls_e;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        cls_e        cls;
    } entry_t;

    function automatic logic is_qnan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && x[9];
    endfunction

    function automatic logic is_snan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && !x[9] && (x[9:0] != 10'd0);
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    endfunction

    // Pair class: first match wins across both operands; -0 (8000) is not ZERO.
    function automatic cls_e classify(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h0000 || b == 16'h0000) return CLS_ZERO;
        if (is_qnan(a) || is_qnan(b))       return CLS_QNAN;
        if (is_snan(a) || is_snan(b))       return CLS_SNAN;
        if (is_inf(a) || is_inf(b))         return CLS_INF;
        return CLS_NORMAL;
    endfunction

    entry_t          mem_q [DEPTH];
    entry_t          head_q, head_d;
    entry_t          new_entry;
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   remain;
    logic            push, pop;

    assign in_ready  = (count_q != CW'(DEPTH)) & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid_q & out_ready & ~flush;
    assign new_entry = '{a: in_a, b: in_b, cls: classify(in_a, in_b)};
    assign remain    = count_q - CW'(pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        head_d      = head_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d     = remain + CW'(push);
            out_valid_d = (count_d != '0);
            // Nothing left behind the head: the incoming pair bypasses storage into the head.
            if (remain == '0) begin
                if (push) head_d = new_entry;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
        if (!nRST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
        end
    end

    // NOTE: storage has no reset; count/pointers decide validity, so stale contents are never observed.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= new_entry;
    end

`ifdef HALF_MULT_EXC_CNT_EN
    logic [7:0] exc_q, exc_d;

    always_comb begin
        exc_d = exc_q;
        if (pop && (head_q.cls inside {CLS_QNAN, CLS_SNAN, CLS_INF}) && exc_q != 8'hFF)
            exc_d = exc_q + 8'd1;
    end

    // Only reset clears the counter; flush leaves it alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) exc_q <= 8'h00;
        else       exc_q <= exc_d;
    end

    assign exc_count = exc_q;
`else
    assign exc_count = 8'h00;
`endif

    assign out_valid  = out_valid_q;
    assign out_float1 = head_q.a;
    assign out_float2 = head_q.b;
    assign out_class  = head_q.cls;
    assign count      = count_q;

endmodule

// File: tb/tb_half_mult_operand_queue.sv
// Scoreboard bench for half_mult_operand_queue: expected pairs queued on push, compared on pop.
// Counter expectations follow HALF_MULT_EXC_CNT_EN.
module tb_half_mult_operand_queue;

    localparam int DEPTH = 4;
`ifdef HALF_MULT_EXC_CNT_EN
    localparam bit EXC_ON = 1'b1;
`else
    localparam bit EXC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_rst;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_a, in_b, out_float1, out_float2;
    logic [2:0]  out_class;
    logic [2:0]  count;
    logic [7:0]  exc_count;

    half_mult_operand_queue #(.DEPTH(DEPTH)) dut (
        .CLK(clk), .nRST(n_rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_float1(out_float1), .out_float2(out_float2), .out_class(out_class),
        .count(count), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  c;
    } pair_t;

    pair_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    exc_model = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference classifier written from the operand fields, one operand class at a time.
    function automatic int op_class(input logic [15:0] x);
        logic [4:0] e;
        logic [9:0] f;
        e = x[14:10];
        f = x[9:0];
        if (x == 16'h0000) return 1;
        if (e != 5'h1F)    return 0;
        if (f == 10'd0)    return 4;
        return f[9] ? 2 : 3;
    endfunction

    function automatic logic [2:0] ref_class(input logic [15:0] a, input logic [15:0] b);
        int ca, cb;
        ca = op_class(a);
        cb = op_class(b);
        if (ca == 1 || cb == 1) return 3'd1;
        if (ca == 2 || cb == 2) return 3'd2;
        if (ca == 3 || cb == 3) return 3'd3;
        if (ca == 4 || cb == 4) return 3'd4;
        return 3'd0;
    endfunction

    // One clock: check against the model at the falling edge, update it, then advance past the rising edge.
    task automatic step();
        pair_t e;
        bit    do_pop, do_push;
        @(negedge clk);
        check("count", count, sb.size());
        check("out_valid", out_valid, sb.size() != 0);
        check("in_ready", in_ready, (sb.size() < DEPTH) && !flush);
        check("exc_count", exc_count, exc_model);
        if (sb.size() != 0) begin
            check("head_a", out_float1, sb[0].a);
            check("head_b", out_float2, sb[0].b);
            check("head_class", out_class, sb[0].c);
        end
        if (flush) begin
            sb.delete();
        end else begin
            do_pop  = (sb.size() != 0) && out_ready;
            do_push = in_valid && (sb.size() < DEPTH);
            if (do_pop) begin
                e = sb.pop_front();
                if (EXC_ON && e.c >= 3'd2 && e.c <= 3'd4 && exc_model < 255) exc_model++;
            end
            if (do_push) sb.push_back({in_a, in_b, ref_class(in_a, in_b)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic rdy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
    endtask

    logic [2:0] exp_cls [4];

    initial begin
        n_rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        #12;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_float1", out_float1, 0);
        check("rst_float2", out_float2, 0);
        check("rst_class", out_class, 0);
        check("rst_exc", exc_count, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // Single push becomes visible the following cycle.
        drive(1'b1, 16'h3C00, 16'h4000, 1'b0);
        step();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        check("first_valid", out_valid, 1);
        check("first_a", out_float1, 16'h3C00);
        check("first_b", out_float2, 16'h4000);
        check("first_class", out_class, 0);
        check("first_count", count, 1);

        // Fill to DEPTH, then try a fifth push while full.
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b1, 16'h3C00 + 16'(i), 16'h4400 + 16'(i), 1'b0);
            step();
        end
        drive(1'b1, 16'h5555, 16'h5555, 1'b0);
        step();
        check("full_count", count, DEPTH);
        check("full_in_ready", in_ready, 0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        for (int i = 0; i < DEPTH; i++) step();
        check("drained_count", count, 0);

        // Class encodings, drained in order across the pointer wrap.
        exp_cls = '{3'd1, 3'd2, 3'd3, 3'd4};
        drive(1'b1, 16'h0000, 16'h7E00, 1'b0); step();
        drive(1'b1, 16'h7E00, 16'h7C01, 1'b0); step();
        drive(1'b1, 16'h7C01, 16'h7C00, 1'b0); step();
        drive(1'b1, 16'h7C00, 16'h3C00, 1'b0); step();
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("class_order", out_class, exp_cls[i]);
            step();
        end
        step();
        check("exc_after4", exc_count, EXC_ON ? 3 : 0);

        // Negative zero alone is NORMAL; subnormal is NORMAL.
        drive(1'b1, 16'h8000, 16'h0001, 1'b0); step();
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        check("neg_zero_class", out_class, 0);
        step();

        // Sustained INF traffic saturates the counter.
        drive(1'b1, 16'h7C00, 16'h3C00, 1'b1);
        for (int i = 0; i < 300; i++) step();
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        step();
        step();
        check("exc_saturated", exc_count, EXC_ON ? 8'hFF : 8'h00);

        // Flush at 3 entries with a simultaneous push and pop request.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h4000 + 16'(i), 16'h4200, 1'b0);
            step();
        end
        flush = 1'b1;
        drive(1'b1, 16'h4800, 16'h4800, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_keeps_exc", exc_count, EXC_ON ? 8'hFF : 8'h00);
        step();

        // Asynchronous reset with two entries queued.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'h3800 + 16'(i), 16'h3A00, 1'b0);
            step();
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        check("pre_reset_count", count, 2);
        #1;
        n_rst = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_valid", out_valid, 0);
        check("async_rst_exc", exc_count, 0);
        sb.delete();
        exc_model = 0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Push after reset and drain back to empty.
        drive(1'b1, 16'h3C00, 16'hC000, 1'b0); step();
        drive(1'b0, 16'h0000, 16'h0000, 1'b1); step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
